// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART host-command front end.
//   state_e    : command FSM states
//   CH_*       : ASCII command and acknowledge bytes
//   to_lower   : folds 'A'..'Z' onto 'a'..'z' (other bytes pass through)
//   hex2nib    : ASCII hex digit -> {valid, nibble}
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_HEX,
        ST_STEP,
        ST_GAP,
        ST_RST,
        ST_ACK
    } state_e;

    localparam logic [7:0] CH_S  = 8'h73;  // 's'
    localparam logic [7:0] CH_N  = 8'h6E;  // 'n'
    localparam logic [7:0] CH_A  = 8'h61;  // 'a'
    localparam logic [7:0] CH_R  = 8'h72;  // 'r'
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_K  = 8'h4B;  // 'K' success
    localparam logic [7:0] CH_H  = 8'h48;  // 'H' CPU halted
    localparam logic [7:0] CH_Q  = 8'h3F;  // '?' error

    function automatic logic [7:0] to_lower(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A) begin
            return c | 8'h20;
        end
        return c;
    endfunction

    function automatic logic [4:0] hex2nib(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) begin
            return {1'b1, c[3:0]};
        end
        // 'A'..'F' / 'a'..'f' have low nibble 1..6
        if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            return {1'b1, c[3:0] + 4'd9};
        end
        return 5'b0_0000;
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Bus bundle between the command parser, the UART FIFOs and the CPU harness.
//   rx_empty/r_data/rd        : UART RX FIFO pop side
//   tx_full/w_data/wr         : UART TX FIFO push side
//   cpu_done/cpu_step/cpu_reset/start_addr : CPU control
//   busy                      : parser not idle
// master = parser side, slave = FIFO/CPU side.
interface uart_cmd_parser_if;
    import uart_cmd_pkg::*;

    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd;
    logic        tx_full;
    logic [7:0]  w_data;
    logic        wr;
    logic        cpu_done;
    logic        cpu_step;
    logic        cpu_reset;
    logic [31:0] start_addr;
    logic        busy;

    modport master (
        input  rx_empty, r_data, tx_full, cpu_done,
        output rd, w_data, wr, cpu_step, cpu_reset, start_addr, busy
    );

    modport slave (
        output rx_empty, r_data, tx_full, cpu_done,
        input  rd, w_data, wr, cpu_step, cpu_reset, start_addr, busy
    );

endinterface

// File: rtl/uart_cmd_parser_cmd_timer.sv
// Loadable down-counter with zero flag.
//   clk, reset  : clock, synchronous active-low reset
//   load_i      : load load_val_i this cycle (has priority over counting)
//   load_val_i  : reload value
//   zero_o      : count is zero (counter holds at zero)
module cmd_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// Host-command parser: pops bytes from the UART RX FIFO, decodes
// s / n<hh> / a<hhhhhhhh> / r commands, drives CPU step/reset/start
// address and pushes a one-byte acknowledge into the UART TX FIFO.
//   clk, reset : clock, synchronous active-low reset
//   bus        : uart_cmd_parser_if.master (FIFO + CPU signals)
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned RST_CYCLES  = 16,
    parameter int unsigned STEP_GAP    = 4,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    uart_cmd_parser_if.master  bus
);

    // Timer is loaded with N-1 so that the owning state lasts N cycles.
    localparam logic [31:0] RST_LOAD = 32'(RST_CYCLES - 1);
    localparam logic [31:0] GAP_LOAD = 32'(STEP_GAP - 1);
    localparam logic [31:0] TO_LOAD  = 32'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;          // remaining steps, up to 256
    logic [3:0]  digits_q, digits_d;    // hex digits still expected
    logic [27:0] shift_q, shift_d;      // argument collected so far
    logic        is_addr_q, is_addr_d;
    logic [31:0] start_addr_q, start_addr_d;
    logic [7:0]  w_data_q, w_data_d;
    logic        holdoff_q;

    logic        rd_c, wr_c, step_c, rstreq_c, can_pop;
    logic        tmr_load, tmr_zero;
    logic [31:0] tmr_val;
    logic [4:0]  nib;
    logic [7:0]  lc;
    logic [31:0] shifted;

    cmd_timer #(.WIDTH(32)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Gating with reset keeps the FIFO untouched while held in reset.
    assign can_pop = reset && !bus.rx_empty && !holdoff_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        digits_d     = digits_q;
        shift_d      = shift_q;
        is_addr_d    = is_addr_q;
        start_addr_d = start_addr_q;
        w_data_d     = w_data_q;
        rd_c         = 1'b0;
        wr_c         = 1'b0;
        step_c       = 1'b0;
        rstreq_c     = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        nib          = hex2nib(bus.r_data);
        lc           = to_lower(bus.r_data);
        shifted      = {shift_q, nib[3:0]};

        case (state_q)
            ST_IDLE: begin
                if (can_pop) begin
                    rd_c = 1'b1;
                    if (bus.r_data == CH_CR || bus.r_data == CH_LF || bus.r_data == CH_SP) begin
                        state_d = ST_IDLE;
                    end else begin
                        case (lc)
                            CH_S: begin
                                cnt_d   = 9'd1;
                                state_d = ST_STEP;
                            end
                            CH_N: begin
                                digits_d  = 4'd2;
                                shift_d   = '0;
                                is_addr_d = 1'b0;
                                tmr_load  = 1'b1;
                                tmr_val   = TO_LOAD;
                                state_d   = ST_GET_HEX;
                            end
                            CH_A: begin
                                digits_d  = 4'd8;
                                shift_d   = '0;
                                is_addr_d = 1'b1;
                                tmr_load  = 1'b1;
                                tmr_val   = TO_LOAD;
                                state_d   = ST_GET_HEX;
                            end
                            CH_R: begin
                                tmr_load = 1'b1;
                                tmr_val  = RST_LOAD;
                                state_d  = ST_RST;
                            end
                            default: begin
                                w_data_d = CH_Q;
                                state_d  = ST_ACK;
                            end
                        endcase
                    end
                end
            end

            ST_GET_HEX: begin
                if (can_pop) begin
                    rd_c     = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TO_LOAD;
                    if (nib[4]) begin
                        shift_d  = shifted[27:0];
                        digits_d = digits_q - 4'd1;
                        if (digits_q == 4'd1) begin
                            if (is_addr_q) begin
                                start_addr_d = shifted;
                                w_data_d     = CH_K;
                                state_d      = ST_ACK;
                            end else begin
                                cnt_d   = (shifted[7:0] == 8'h00) ? 9'd256 : {1'b0, shifted[7:0]};
                                state_d = ST_STEP;
                            end
                        end
                    end else begin
                        w_data_d = CH_Q;
                        state_d  = ST_ACK;
                    end
                end else if (tmr_zero) begin
                    w_data_d = CH_Q;
                    state_d  = ST_ACK;
                end
            end

            ST_STEP: begin
                if (bus.cpu_done) begin
                    w_data_d = CH_H;
                    state_d  = ST_ACK;
                end else begin
                    step_c = 1'b1;
                    cnt_d  = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        w_data_d = CH_K;
                        state_d  = ST_ACK;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                        state_d  = ST_GAP;
                    end
                end
            end

            ST_GAP: begin
                if (tmr_zero) begin
                    state_d = ST_STEP;
                end
            end

            ST_RST: begin
                rstreq_c = 1'b1;
                if (tmr_zero) begin
                    w_data_d = CH_K;
                    state_d  = ST_ACK;
                end
            end

            ST_ACK: begin
                if (!bus.tx_full) begin
                    wr_c    = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            digits_q     <= '0;
            shift_q      <= '0;
            is_addr_q    <= 1'b0;
            start_addr_q <= '0;
            w_data_q     <= '0;
            holdoff_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digits_q     <= digits_d;
            shift_q      <= shift_d;
            is_addr_q    <= is_addr_d;
            start_addr_q <= start_addr_d;
            w_data_q     <= w_data_d;
            holdoff_q    <= rd_c;
        end
    end

    assign bus.rd         = rd_c;
    assign bus.wr         = wr_c;
    assign bus.cpu_step   = step_c;
    assign bus.cpu_reset  = rstreq_c;
    assign bus.w_data     = w_data_q;
    assign bus.start_addr = start_addr_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Host-command front end for the board-test CPU harness.
- Pops bytes from the UART receive FIFO (uart `r_data`/`rx_empty`/`rd`) and decodes single-letter commands.
- Drives the CPU step, reset and start-address inputs, replacing the push-button path.
- Returns a one-byte acknowledge into the UART transmit FIFO (`w_data`/`wr`/`tx_full`).

Parameters:
- RST_CYCLES, 16: clocks cpu_reset is held high per 'r' command (>=1).
- STEP_GAP, 4: idle clocks between consecutive step pulses in an 'n' burst (>=1).
- TIMEOUT_CYC, 50_000_000: max clocks between hex digits before the argument is abandoned.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- rx_empty  in  1  UART RX FIFO empty
- r_data  in  8  UART RX FIFO head byte, valid while rx_empty=0
- rd  out  1  RX FIFO pop, one-cycle pulse
- tx_full  in  1  UART TX FIFO full
- w_data  out  8  acknowledge byte
- wr  out  1  TX FIFO push, one-cycle pulse
- cpu_done  in  1  CPU halted flag
- cpu_step  out  1  one-cycle step pulse to CPU clock-enable
- cpu_reset  out  1  CPU reset request, active-high
- start_addr  out  32  CPU start address
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0 at clk edge), regardless of current state:
  - state IDLE; all counters cleared.
  - rd=0, wr=0, cpu_step=0, cpu_reset=0, busy=0, w_data=8'h00.
  - start_addr=32'h0000_0000.
- Pop rule:
  - In a byte-wanting state with rx_empty=0: assert rd for one cycle and consume r_data in that same cycle.
  - rd is never asserted in the cycle immediately following a pop (one-cycle holdoff for FIFO flag update).
- States: IDLE, GET_HEX, STEP, GAP, RST, ACK.
- IDLE, on byte (case-insensitive):
  - 's': step count=1 -> STEP.
  - 'n': expect 2 hex digits -> GET_HEX.
  - 'a': expect 8 hex digits -> GET_HEX.
  - 'r': -> RST.
  - CR, LF, space: ignored, stay IDLE.
  - anything else: ack '?' -> ACK.
- GET_HEX:
  - Each valid digit (0-9, a-f, A-F) shifts in MS-nibble first.
  - Non-hex byte: ack '?', argument discarded, start_addr unchanged.
  - TIMEOUT_CYC clocks with no byte: ack '?'; the idle counter restarts at every pop.
  - On the last digit of 'a': start_addr updates on the next edge, ack 'K'.
  - On the last digit of 'n': count = value, with 8'h00 meaning 256 -> STEP.
- STEP:
  - If cpu_done=1: ack 'H', remaining count discarded.
  - Else: cpu_step=1 for exactly one cycle, count decremented.
  - Count reaches 0: ack 'K'.
  - Otherwise -> GAP for STEP_GAP cycles -> STEP.
- RST:
  - cpu_reset=1 for exactly RST_CYCLES cycles, then ack 'K'.
  - start_addr is not altered.
- ACK:
  - Waits while tx_full=1.
  - When tx_full=0: w_data=ack byte and wr=1 for one cycle -> IDLE.
  - w_data holds its value after the push.
- RX bytes arriving during STEP/GAP/RST/ACK stay in the FIFO (no pop) and are processed afterwards.
- Simultaneous events:
  - cpu_done rising in the same cycle as a step pulse: the pulse is already issued; the halt is seen at the next STEP entry.
  - Reset during RST deasserts cpu_reset on that same edge.
- Latency:
  - 's' pop -> cpu_step high 1 cycle later.
  - 'a' final-digit pop -> start_addr valid 1 cycle later.
  - wr follows end of operation by 1 cycle when TX is not full.

Decomposition:
- Shared package uart_cmd_pkg:
  - state enum.
  - ASCII constants for 's', 'n', 'a', 'r', CR, LF, SP, 'K', 'H', '?'.
  - function hex2nib returning {valid, nibble}.
- One sub-module, cmd_timer: loadable down-counter with zero flag, used for RST_CYCLES, STEP_GAP and TIMEOUT_CYC (one instance, reloaded per state).

Test Plan:
- Bytes "s" -> exactly one cpu_step pulse, then wr with w_data=8'h4B ('K'); busy low afterwards.
- "n05", STEP_GAP=4 -> five cpu_step pulses 5 clocks apart (first-to-last 20 clocks), single 'K'.
- "a0040001C" -> start_addr=32'h0040_001C, ack 'K'; then "a12x" -> ack '?', start_addr stays 32'h0040_001C.
- "nFF" with cpu_done forced high after the 3rd pulse -> exactly 3 pulses, ack 'H' (8'h48).
- "r", RST_CYCLES=16, tx_full held high 10 cycles after the reset window -> cpu_reset high 16 cycles; wr delayed until tx_full falls, w_data='K'.
- reset low mid-"n0A" burst, plus "q" sent with RX FIFO back-to-back bytes "qs" -> reset clears all outputs within one edge; then "q" gives '?', then "s" pops correctly with no double pop (holdoff checked).
